// File: rtl/picoview_spi_master.sv
// rtl/picoview_spi_master.sv - SPI initiator for the picoview register protocol
// Sends an 8-bit command byte and a 32-bit data word, and captures the returned 32-bit word.
module picoview_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int CMD_GAP = 16,
  parameter int CS_IDLE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_write,
  input  logic [6:0]  register_number,
  input  logic [31:0] write_data,
  output logic        ready,
  output logic        done,
  output logic [31:0] read_data,
  output logic        sck,
  output logic        sdo,
  input  logic        sdi,
  output logic        cs
);

  localparam int MAX_A   = (CLK_DIV > CMD_GAP) ? CLK_DIV : CMD_GAP;
  localparam int MAX_CNT = (MAX_A > CS_IDLE) ? MAX_A : CS_IDLE;
  localparam int PW      = $clog2(MAX_CNT);

  localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GAP_LAST = PW'(CMD_GAP - 1);
  // The cycle in which ready is seen also keeps cs high, so RECOVER is one short of CS_IDLE.
  localparam logic [PW-1:0] REC_LAST = PW'((CS_IDLE > 1) ? CS_IDLE - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CMD,
    S_GAP,
    S_DATA,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] phase_cnt;
  logic [5:0]    bit_cnt;
  logic          sck_high;
  logic [39:0]   tx_shift;
  logic [31:0]   rx_shift;

  logic          phase_end;
  logic          load;
  logic          sck_rise;
  logic          bit_end;
  logic          finish;

  always_comb begin
    state_next = state;
    phase_end  = 1'b0;
    load       = 1'b0;
    sck_rise   = 1'b0;
    bit_end    = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_cnt == DIV_LAST) begin
          phase_end  = 1'b1;
          state_next = S_CMD;
        end
      end
      S_CMD, S_DATA: begin
        if (phase_cnt == DIV_LAST) begin
          phase_end = 1'b1;
          if (!sck_high) begin
            sck_rise = 1'b1;
          end else begin
            // End of the high phase: sample sdi, then sck falls and sdo advances.
            bit_end = 1'b1;
            if (state == S_CMD && bit_cnt == 6'd7) begin
              state_next = S_GAP;
            end
            if (state == S_DATA && bit_cnt == 6'd39) begin
              state_next = S_HOLD;
            end
          end
        end
      end
      S_GAP: begin
        if (phase_cnt == GAP_LAST) begin
          phase_end  = 1'b1;
          state_next = S_DATA;
        end
      end
      S_HOLD: begin
        if (phase_cnt == DIV_LAST) begin
          phase_end  = 1'b1;
          finish     = 1'b1;
          state_next = (CS_IDLE > 1) ? S_RECOVER : S_IDLE;
        end
      end
      S_RECOVER: begin
        if (phase_cnt == REC_LAST) begin
          phase_end  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      bit_cnt   <= 6'd0;
      sck_high  <= 1'b0;
      tx_shift  <= 40'd0;
      rx_shift  <= 32'd0;
      read_data <= 32'd0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= finish;

      if (state == S_IDLE || phase_end) begin
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + PW'(1);
      end

      if (load) begin
        tx_shift <= {is_write, register_number, (is_write ? write_data : 32'd0)};
        bit_cnt  <= 6'd0;
      end else if (bit_end) begin
        tx_shift <= {tx_shift[38:0], 1'b0};
        bit_cnt  <= (bit_cnt == 6'd39) ? 6'd0 : bit_cnt + 6'd1;
      end

      // Command-phase bits are shifted out of the top by the 32 data-phase samples.
      if (bit_end) begin
        rx_shift <= {rx_shift[30:0], sdi};
      end

      if (finish) begin
        read_data <= rx_shift;
      end

      if (sck_rise) begin
        sck_high <= 1'b1;
      end else if (bit_end) begin
        sck_high <= 1'b0;
      end
    end
  end

  assign ready = (state == S_IDLE);
  assign cs    = (state == S_IDLE) || (state == S_RECOVER);
  assign sck   = sck_high;
  assign sdo   = cs ? 1'b0 : tx_shift[39];

endmodule

// File: tb/tb_picoview_spi_master.sv
// tb/tb_picoview_spi_master.sv - directed bench for picoview_spi_master
// A default build and a CLK_DIV=3/CMD_GAP=4 build, each with a peripheral model on the SPI pins.
module tb_picoview_spi_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start3 = 1'b0;
  logic        is_write = 1'b0;
  logic [6:0]  register_number = 7'd0;
  logic [31:0] write_data = 32'd0;

  logic        ready, done, sck, sdo, cs;
  logic        sdi = 1'b0;
  logic [31:0] read_data;
  logic        ready3, done3, sck3, sdo3, cs3;
  logic        sdi3 = 1'b0;
  logic [31:0] read_data3;

  always #5 clk = ~clk;

  picoview_spi_master u_dut (
    .clk(clk), .reset(reset), .start(start), .is_write(is_write),
    .register_number(register_number), .write_data(write_data),
    .ready(ready), .done(done), .read_data(read_data),
    .sck(sck), .sdo(sdo), .sdi(sdi), .cs(cs)
  );

  picoview_spi_master #(.CLK_DIV(3), .CMD_GAP(4), .CS_IDLE(8)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .is_write(is_write),
    .register_number(register_number), .write_data(write_data),
    .ready(ready3), .done(done3), .read_data(read_data3),
    .sck(sck3), .sdo(sdo3), .sdi(sdi3), .cs(cs3)
  );

  int passed = 0;
  int total = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Peripheral model for the default build: mode 0, answer word shifted out after the command byte.
  logic        sck_d = 1'b0, cs_d = 1'b1;
  int          rises = 0, cs_low = 0, cs_high = 0, done_cnt = 0;
  int          last_rises = 0, last_cs_low = 0, last_cs_high = 0;
  logic [39:0] bfm_shift = 40'd0, last_shift = 40'd0;
  logic [31:0] bfm_word = 32'd0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (sck && !sck_d) begin
      bfm_shift = {bfm_shift[38:0], sdo};
      rises++;
    end
    if (!sck && sck_d) sdi = (rises >= 8 && rises < 40) ? bfm_word[39-rises] : 1'b0;
    if (!cs) begin
      if (cs_d) begin
        last_cs_high = cs_high;
        rises = 0;
        bfm_shift = 40'd0;
        cs_low = 0;
      end
      cs_low++;
    end else begin
      if (!cs_d) begin
        last_cs_low = cs_low;
        last_rises = rises;
        last_shift = bfm_shift;
        cs_high = 0;
      end
      cs_high++;
    end
    sck_d = sck;
    cs_d = cs;
  end

  // Peripheral model for the CLK_DIV=3 build, also measuring sck phase lengths.
  logic        sck3_d = 1'b0, cs3_d = 1'b1;
  int          rises3 = 0, hi_run = 0, lo_run = 0, hi_bad = 0, lo_bad = 0, gap_run3 = 0;
  logic [31:0] word3 = 32'hFFFF0001;

  always @(negedge clk) begin
    if (!cs3 && cs3_d) begin
      rises3 = 0; hi_bad = 0; lo_bad = 0; lo_run = 0; hi_run = 0;
    end
    if (!cs3) begin
      if (sck3 && !sck3_d) begin
        if (rises3 == 8) gap_run3 = lo_run;
        else if (rises3 != 0 && lo_run != 3) lo_bad++;
        rises3++;
        hi_run = 0;
      end
      if (!sck3 && sck3_d) begin
        if (hi_run != 3) hi_bad++;
        lo_run = 0;
        sdi3 = (rises3 >= 8 && rises3 < 40) ? word3[39-rises3] : 1'b0;
      end
      if (sck3) hi_run++;
      else lo_run++;
    end
    sck3_d = sck3;
    cs3_d = cs3;
  end

  // Called on a negedge with the chosen DUT ready; returns the cycle number of the start cycle.
  task automatic send(input bit which, input bit w, input logic [6:0] r, input logic [31:0] d,
                      output int at);
    is_write = w;
    register_number = r;
    write_data = d;
    if (which) start3 = 1'b1;
    else start = 1'b1;
    at = cyc;
    @(negedge clk);
    start = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input string tag, output int at);
    at = -1;
    for (int i = 0; i < 1000; i++) begin
      if (which ? done3 : done) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    int ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      if (ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok == 0) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  int t0, t1, dc0, seen;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rdata", read_data, 32'd0);

    // Write reg 3 = 0xA5; peripheral returns its prior readback value
    bfm_word = 32'h5A5A0F0F;
    dc0 = done_cnt;
    send(1'b0, 1'b1, 7'd3, 32'h0000_00A5, t0);
    wait_done(1'b0, "wr", t1);
    chk("wr_latency", 32'(t1 - t0), 32'd345);
    chk("wr_rdata", read_data, 32'h5A5A0F0F);
    @(negedge clk);
    chk("wr_cmd", 32'(last_shift[39:32]), 32'h83);
    chk("wr_data", last_shift[31:0], 32'h0000_00A5);
    chk("wr_rises", 32'(last_rises), 32'd40);
    chk("wr_cs_low", 32'(last_cs_low), 32'd344);
    chk("wr_done_cnt", 32'(done_cnt - dc0), 32'd1);

    // Read ID register 0x7F with nonzero write_data, which must not reach sdo
    wait_ready("rd_id");
    bfm_word = 32'hC001CAFE;
    send(1'b0, 1'b0, 7'h7F, 32'hFFFF_FFFF, t0);
    wait_done(1'b0, "rd_id", t1);
    chk("rd_id_rdata", read_data, 32'hC001CAFE);
    @(negedge clk);
    chk("rd_id_cmd", 32'(last_shift[39:32]), 32'h7F);
    chk("rd_id_sdo_data", last_shift[31:0], 32'd0);

    // start held for 3 cycles, then a stray start while busy
    wait_ready("hold");
    bfm_word = 32'h13572468;
    dc0 = done_cnt;
    is_write = 1'b0;
    register_number = 7'd2;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (800) @(negedge clk);
    chk("hold_done_cnt", 32'(done_cnt - dc0), 32'd1);
    chk("hold_rdata", read_data, 32'h13572468);
    chk("hold_ready", 32'(ready), 32'd1);

    // Asynchronous reset during data bit 20, with sck high
    bfm_word = 32'hDEADBEEF;
    send(1'b0, 1'b0, 7'd4, 32'd0, t0);
    seen = 0;
    for (int i = 0; i < 600; i++) begin
      if (rises == 28 && sck) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("arst_reached_bit20", 32'(seen), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_cs", 32'(cs), 32'd1);
    chk("arst_sck", 32'(sck), 32'd0);
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_rdata", read_data, 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bfm_word = 32'h0BADF00D;
    send(1'b0, 1'b0, 7'd5, 32'd0, t0);
    wait_done(1'b0, "post_rst", t1);
    chk("post_rst_rdata", read_data, 32'h0BADF00D);
    @(negedge clk);
    chk("post_rst_cmd", 32'(last_shift[39:32]), 32'h05);
    chk("post_rst_cs_low", 32'(last_cs_low), 32'd344);

    // Back-to-back reads: second start in the cycle ready rises
    wait_ready("b2b");
    bfm_word = 32'h12345678;
    send(1'b0, 1'b0, 7'h10, 32'd0, t0);
    wait_done(1'b0, "b2b_1", t1);
    chk("b2b_rdata1", read_data, 32'h12345678);
    bfm_word = 32'h9ABCDEF0;
    @(negedge clk);
    wait_ready("b2b_2");
    send(1'b0, 1'b0, 7'h11, 32'd0, t0);
    wait_done(1'b0, "b2b_2", t1);
    chk("b2b_rdata2", read_data, 32'h9ABCDEF0);
    @(negedge clk);
    chk("b2b_cs_high", 32'(last_cs_high), 32'd8);

    // CLK_DIV=3, CMD_GAP=4 build: read of reg 1
    send(1'b1, 1'b0, 7'd1, 32'd0, t0);
    wait_done(1'b1, "div3", t1);
    chk("div3_latency", 32'(t1 - t0), 32'd251);
    chk("div3_rdata", read_data3, 32'hFFFF0001);
    @(negedge clk);
    chk("div3_rises", 32'(rises3), 32'd40);
    chk("div3_hi_bad", 32'(hi_bad), 32'd0);
    chk("div3_lo_bad", 32'(lo_bad), 32'd0);
    chk("div3_gap_low", 32'(gap_run3), 32'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
